// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared encodings for the RAM port arbiter (FSM state, owner, op)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic [0:0] {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef enum logic [0:0] {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // The requester that did not receive the previous grant.
  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CPU) ? OWN_HOST : OWN_CPU;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Combinational two-requester round-robin grant (CPU vs host).
//             The last-grant history is kept by the parent.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   req_cpu,
  input  logic   req_host,
  input  owner_e last_grant,
  output logic   gnt_valid,
  output owner_e gnt_owner
);

  // Sole requester wins; on contention the one not granted last time wins.
  always_comb begin
    gnt_valid = req_cpu | req_host;
    gnt_owner = OWN_CPU;
    if (req_cpu && req_host) begin
      gnt_owner = other_owner(last_grant);
    end else if (req_host) begin
      gnt_owner = OWN_HOST;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-port synchronous RAM between the CPU memory
//             interface and the host loader/debug port. One transaction in
//             flight, round-robin on contention, no preemption.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  // CPU side
  input  logic [31:0]       cpu_Address,
  input  logic              cpu_MemRead,
  input  logic              cpu_MemWrite,
  input  logic [31:0]       cpu_Write_data,
  input  logic [3:0]        cpu_Write_strb,
  output logic              cpu_Mem_Req_Ready,
  output logic [31:0]       cpu_Read_data,
  output logic              cpu_Read_data_Valid,
  input  logic              cpu_Read_data_Ready,
  // Host side
  input  logic [31:0]       host_addr,
  input  logic              host_rd,
  input  logic              host_wr,
  input  logic [31:0]       host_wdata,
  input  logic [3:0]        host_wstrb,
  output logic              host_req_ready,
  output logic [31:0]       host_rdata,
  output logic              host_rvalid,
  input  logic              host_rready,
  // RAM side
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_e             state_q, state_d;
  owner_e             last_grant_q, last_grant_d;
  owner_e             owner_q, owner_d;
  op_e                op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic [31:0]        host_rdata_q, host_rdata_d;

  logic   req_cpu;
  logic   req_host;
  logic   gnt_valid;
  owner_e gnt_owner;
  logic   grant_open;
  logic   owner_rready;

  // Byte-offset and out-of-range address bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_Address[31:ADDR_W+2], cpu_Address[1:0],
                              host_addr[31:ADDR_W+2], host_addr[1:0]};

  assign req_cpu  = cpu_MemRead | cpu_MemWrite;
  assign req_host = host_rd | host_wr;

  rr_arb2 u_rr_arb2 (
    .req_cpu    (req_cpu),
    .req_host   (req_host),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  // Ready is only offered in IDLE, and held low while reset is asserted.
  assign grant_open        = resetn && (state_q == IDLE) && gnt_valid;
  assign cpu_Mem_Req_Ready = grant_open && (gnt_owner == OWN_CPU);
  assign host_req_ready    = grant_open && (gnt_owner == OWN_HOST);

  assign owner_rready = (owner_q == OWN_CPU) ? cpu_Read_data_Ready : host_rready;

  // Valid only toward the owner of the transaction being answered.
  assign cpu_Read_data_Valid = (state_q == RESP) && (owner_q == OWN_CPU);
  assign host_rvalid         = (state_q == RESP) && (owner_q == OWN_HOST);
  assign cpu_Read_data       = cpu_rdata_q;
  assign host_rdata          = host_rdata_q;

  // State and transaction registers; reset drops any in-flight read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_HOST;
      owner_q      <= OWN_CPU;
      op_q         <= OP_RD;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      count_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      count_q      <= count_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Next-state: accept in IDLE, one RAM cycle in ACCESS, count out the read
  // latency in WAIT, then hold the response until the owner takes it.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    count_d      = count_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d      = gnt_owner;
          last_grant_d = gnt_owner;
          state_d      = ACCESS;
          if (gnt_owner == OWN_CPU) begin
            op_d    = cpu_MemWrite ? OP_WR : OP_RD;
            addr_d  = cpu_Address[ADDR_W+1:2];
            wdata_d = cpu_Write_data;
            wstrb_d = cpu_Write_strb;
          end else begin
            op_d    = host_wr ? OP_WR : OP_RD;
            addr_d  = host_addr[ADDR_W+1:2];
            wdata_d = host_wdata;
            wstrb_d = host_wstrb;
          end
        end
      end
      ACCESS: begin
        if (op_q == OP_WR) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          count_d = CNT_INIT;
        end
      end
      WAIT: begin
        count_d = count_q - CNT_LAST;
        if (count_q == CNT_LAST) begin
          state_d = RESP;
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = mem_rdata;
          end else begin
            host_rdata_d = mem_rdata;
          end
        end
      end
      RESP: begin
        if (owner_rready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM port is driven only during the single ACCESS cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_en   = 1'b1;
      mem_addr = addr_q;
      if (op_q == OP_WR) begin
        mem_wen   = wstrb_q;
        mem_wdata = wdata_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed scoreboard bench for mem_port_arbiter with a
//             behavioural single-port RAM (read latency 1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 12;
  localparam int RD_LATENCY = 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic [31:0]       cpu_Address;
  logic              cpu_MemRead, cpu_MemWrite;
  logic [31:0]       cpu_Write_data;
  logic [3:0]        cpu_Write_strb;
  logic              cpu_Mem_Req_Ready;
  logic [31:0]       cpu_Read_data;
  logic              cpu_Read_data_Valid;
  logic              cpu_Read_data_Ready;
  logic [31:0]       host_addr;
  logic              host_rd, host_wr;
  logic [31:0]       host_wdata;
  logic [3:0]        host_wstrb;
  logic              host_req_ready;
  logic [31:0]       host_rdata;
  logic              host_rvalid;
  logic              host_rready;
  logic              mem_en;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_LATENCY)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .cpu_Address         (cpu_Address),
    .cpu_MemRead         (cpu_MemRead),
    .cpu_MemWrite        (cpu_MemWrite),
    .cpu_Write_data      (cpu_Write_data),
    .cpu_Write_strb      (cpu_Write_strb),
    .cpu_Mem_Req_Ready   (cpu_Mem_Req_Ready),
    .cpu_Read_data       (cpu_Read_data),
    .cpu_Read_data_Valid (cpu_Read_data_Valid),
    .cpu_Read_data_Ready (cpu_Read_data_Ready),
    .host_addr           (host_addr),
    .host_rd             (host_rd),
    .host_wr             (host_wr),
    .host_wdata          (host_wdata),
    .host_wstrb          (host_wstrb),
    .host_req_ready      (host_req_ready),
    .host_rdata          (host_rdata),
    .host_rvalid         (host_rvalid),
    .host_rready         (host_rready),
    .mem_en              (mem_en),
    .mem_wen             (mem_wen),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: background word i = 0xC0DE_iiii, a few words preset.
  logic [31:0] ram [0:4095];
  logic        ram_init_done = 1'b0;
  logic [31:0] ram_q;
  assign mem_rdata = ram_q;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 4096; i++) ram[i] <= {16'hC0DE, 16'(i)};
      ram[3] <= 32'h0;
      ram[4] <= 32'h12345678;
      ram[8] <= 32'h0;
      ram[9] <= 32'h0;
      ram_init_done <= 1'b1;
    end else if (mem_en) begin
      ram_q <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Scoreboard state
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wen;
    logic [31:0]       wdata;
  } mem_exp_t;

  mem_exp_t    exp_mem[$];
  logic [31:0] exp_cpu[$];
  logic [31:0] exp_host[$];

  int n_vec = 0;
  int n_err = 0;
  int cpu_done = 0;
  int host_done = 0;
  int last_mem_cyc = -1;
  int cpu_vfirst_cyc = -1;
  logic cpu_v_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name, input string detail);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  // RAM-port monitor: every enabled cycle must match the next expected access.
  initial forever begin
    mem_exp_t e;
    @(negedge clk);
    chk("one_ready", {127'b0, cpu_Mem_Req_Ready & host_req_ready}, 128'b0);
    if (mem_en) begin
      last_mem_cyc = cyc;
      if (exp_mem.size() == 0) begin
        fail_msg("mem_unexpected", $sformatf("got access addr=%0d wen=%b, expected none", mem_addr, mem_wen));
      end else begin
        e = exp_mem.pop_front();
        chk("mem_port", {76'b0, mem_addr, mem_wen, mem_wdata}, {76'b0, e});
      end
    end else begin
      chk("mem_idle_zero", {80'b0, mem_wen, mem_addr, mem_wdata}, 128'b0);
    end
  end

  // CPU response monitor
  initial forever begin
    @(negedge clk);
    if (cpu_Read_data_Valid && !cpu_v_prev) cpu_vfirst_cyc = cyc;
    cpu_v_prev = cpu_Read_data_Valid;
    if (cpu_Read_data_Valid && cpu_Read_data_Ready) begin
      if (exp_cpu.size() == 0)
        fail_msg("cpu_rvalid_unexpected", $sformatf("got valid data 0x%0h, expected no response", cpu_Read_data));
      else
        chk("cpu_rdata", {96'b0, cpu_Read_data}, {96'b0, exp_cpu.pop_front()});
      cpu_done++;
    end
  end

  // Host response monitor
  initial forever begin
    @(negedge clk);
    if (host_rvalid && host_rready) begin
      if (exp_host.size() == 0)
        fail_msg("host_rvalid_unexpected", $sformatf("got valid data 0x%0h, expected no response", host_rdata));
      else
        chk("host_rdata", {96'b0, host_rdata}, {96'b0, exp_host.pop_front()});
      host_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  task automatic cpu_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int acc);
    @(posedge clk); #1;
    cpu_Address = a; cpu_Write_data = d; cpu_Write_strb = s;
    cpu_MemWrite = wr; cpu_MemRead = !wr;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cpu_Mem_Req_Ready) begin acc = cyc; break; end
    end
    if (acc < 0) fail_msg("cpu_req_timeout", "got no cpu_Mem_Req_Ready in 100 cycles, expected grant");
    @(posedge clk); #1;
    cpu_MemRead = 1'b0; cpu_MemWrite = 1'b0;
  endtask

  task automatic host_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int acc);
    @(posedge clk); #1;
    host_addr = a; host_wdata = d; host_wstrb = s;
    host_wr = wr; host_rd = !wr;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (host_req_ready) begin acc = cyc; break; end
    end
    if (acc < 0) fail_msg("host_req_timeout", "got no host_req_ready in 100 cycles, expected grant");
    @(posedge clk); #1;
    host_rd = 1'b0; host_wr = 1'b0;
  endtask

  task automatic wait_cpu(input int target);
    for (int i = 0; i < 100 && cpu_done < target; i++) @(negedge clk);
    if (cpu_done < target) fail_msg("cpu_resp_timeout", $sformatf("got %0d responses, expected %0d", cpu_done, target));
  endtask

  task automatic wait_host(input int target);
    for (int i = 0; i < 100 && host_done < target; i++) @(negedge clk);
    if (host_done < target) fail_msg("host_resp_timeout", $sformatf("got %0d responses, expected %0d", host_done, target));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
  endtask

  function automatic mem_exp_t rd(input int w);
    return '{addr: ADDR_W'(w), wen: 4'b0000, wdata: 32'h0};
  endfunction

  initial begin
    int acc, acc2, t;
    resetn = 1'b0;
    cpu_Address = '0; cpu_MemRead = 1'b0; cpu_MemWrite = 1'b0;
    cpu_Write_data = '0; cpu_Write_strb = '0; cpu_Read_data_Ready = 1'b1;
    host_addr = '0; host_rd = 1'b0; host_wr = 1'b0;
    host_wdata = '0; host_wstrb = '0; host_rready = 1'b1;

    // Reset state: all outputs low during and after reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {11'b0, cpu_Mem_Req_Ready, cpu_Read_data, cpu_Read_data_Valid, host_req_ready,
        host_rdata, host_rvalid, mem_en, mem_wen, mem_addr, mem_wdata}, 128'b0);
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {11'b0, cpu_Mem_Req_Ready, cpu_Read_data, cpu_Read_data_Valid, host_req_ready,
        host_rdata, host_rvalid, mem_en, mem_wen, mem_addr, mem_wdata}, 128'b0);

    // 1: CPU read of byte 0x10 -> word 4, access at +1, valid at +3
    exp_mem.push_back(rd(4));
    exp_cpu.push_back(32'h12345678);
    t = cpu_done + 1;
    cpu_txn(1'b0, 32'h10, 32'h0, 4'h0, acc);
    wait_cpu(t);
    chk("t1_access_cycle", 128'(last_mem_cyc), 128'(acc + 1));
    chk("t1_valid_cycle", 128'(cpu_vfirst_cyc), 128'(acc + RD_LATENCY + 2));

    // 2: after reset, simultaneous writes -> CPU first (word 8), host next (word 9)
    do_reset();
    exp_mem.push_back('{addr: 12'd8, wen: 4'b1111, wdata: 32'h11111111});
    exp_mem.push_back('{addr: 12'd9, wen: 4'b1111, wdata: 32'h22222222});
    fork
      begin int a1; cpu_txn(1'b1, 32'h20, 32'h11111111, 4'b1111, a1); end
      begin int a2; host_txn(1'b1, 32'h24, 32'h22222222, 4'b1111, a2); end
    join
    exp_mem.push_back(rd(8));
    exp_cpu.push_back(32'h11111111);
    t = cpu_done + 1;
    cpu_txn(1'b0, 32'h20, 32'h0, 4'h0, acc);
    wait_cpu(t);
    exp_mem.push_back(rd(9));
    exp_host.push_back(32'h22222222);
    t = host_done + 1;
    host_txn(1'b0, 32'h24, 32'h0, 4'h0, acc);
    wait_host(t);

    // 3: CPU response back-pressured 5 cycles while host waits
    cpu_Read_data_Ready = 1'b0;
    exp_mem.push_back(rd(16));
    exp_mem.push_back(rd(17));
    exp_cpu.push_back(32'hC0DE0010);
    exp_host.push_back(32'hC0DE0011);
    t = host_done + 1;
    fork
      begin
        int a3;
        bit seen;
        cpu_txn(1'b0, 32'h40, 32'h0, 4'h0, a3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (cpu_Read_data_Valid) begin seen = 1'b1; break; end
        end
        if (!seen) fail_msg("t3_valid_timeout", "got no cpu_Read_data_Valid, expected it within 20 cycles");
        for (int k = 0; k < 5; k++) begin
          chk("t3_hold", {94'b0, cpu_Read_data_Valid, host_req_ready, cpu_Read_data},
              {94'b0, 1'b1, 1'b0, 32'hC0DE0010});
          @(negedge clk);
        end
        @(posedge clk); #1 cpu_Read_data_Ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_host_grant_next", {127'b0, host_req_ready}, 128'd1);
      end
      begin
        int a4;
        @(posedge clk); #1;
        host_txn(1'b0, 32'h44, 32'h0, 4'h0, a4);
      end
    join
    wait_host(t);

    // 4: partial-strobe write, then readback and write turnaround
    exp_mem.push_back('{addr: 12'd3, wen: 4'b0010, wdata: 32'hAABBCCDD});
    exp_mem.push_back(rd(3));
    exp_cpu.push_back(32'h0000CC00);
    t = cpu_done + 1;
    cpu_txn(1'b1, 32'h0C, 32'hAABBCCDD, 4'b0010, acc);
    cpu_txn(1'b0, 32'h0C, 32'h0, 4'h0, acc2);
    chk("t4_write_turnaround", 128'(acc2), 128'(acc + 2));
    wait_cpu(t);

    // 5: reset during WAIT of a host read drops it
    exp_mem.push_back(rd(20));
    host_txn(1'b0, 32'h50, 32'h0, 4'h0, acc);
    @(posedge clk); #1 resetn = 1'b0;
    #1;
    chk("t5_async_reset_outputs", {11'b0, cpu_Mem_Req_Ready, cpu_Read_data, cpu_Read_data_Valid, host_req_ready,
        host_rdata, host_rvalid, mem_en, mem_wen, mem_addr, mem_wdata}, 128'b0);
    @(posedge clk); #1 resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_stale_rvalid", {127'b0, host_rvalid}, 128'b0);
    end
    exp_mem.push_back(rd(21));
    exp_host.push_back(32'hC0DE0015);
    t = host_done + 1;
    host_txn(1'b0, 32'h54, 32'h0, 4'h0, acc);
    wait_host(t);

    // 6: continuous contention -> strict alternation starting with CPU
    for (int i = 0; i < 5; i++) begin
      exp_mem.push_back(rd(32 + i));
      exp_mem.push_back(rd(48 + i));
      exp_cpu.push_back(32'hC0DE0020 + 32'(i));
      exp_host.push_back(32'hC0DE0030 + 32'(i));
    end
    acc = cpu_done;
    acc2 = host_done;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          int a5, tc;
          tc = cpu_done + 1;
          cpu_txn(1'b0, 32'h80 + 32'(4 * i), 32'h0, 4'h0, a5);
          wait_cpu(tc);
        end
      end
      begin
        for (int j = 0; j < 5; j++) begin
          int a6, th;
          th = host_done + 1;
          host_txn(1'b0, 32'hC0 + 32'(4 * j), 32'h0, 4'h0, a6);
          wait_host(th);
        end
      end
    join
    chk("t6_cpu_grants", 128'(cpu_done - acc), 128'd5);
    chk("t6_host_grants", 128'(host_done - acc2), 128'd5);

    repeat (4) @(negedge clk);
    chk("queues_drained", 128'(exp_mem.size() + exp_cpu.size() + exp_host.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
